// File: rtl/fetch_pc_gen_if.sv
// rtl/fetch_pc_gen_if.sv - fetch request/response handshake bundle between PC generator and I-side
//
// Purpose: carries one fetch request (valid/ready with address and epoch tag)
// and the matching response (valid, returned epoch, compressed flag).
//
// Signals:
//   req_valid       request valid (PC generator -> I-side)
//   req_ready       I-side accepts the request (I-side -> PC generator)
//   req_pc          fetch address, XLEN bits
//   req_epoch       epoch tag of the request, EPOCH_W bits
//   rsp_valid       fetch response valid (I-side -> PC generator)
//   rsp_epoch       epoch tag returned with the response
//   rsp_compressed  response holds a 16-bit instruction
//
// Modports:
//   master  the PC generator side (drives the request, consumes the response)
//   slave   the I-side (consumes the request, drives the response)

interface fetch_pc_gen_if #(
  parameter int XLEN    = 64,
  parameter int EPOCH_W = 2
);

  logic               req_valid;
  logic               req_ready;
  logic [XLEN-1:0]    req_pc;
  logic [EPOCH_W-1:0] req_epoch;
  logic               rsp_valid;
  logic [EPOCH_W-1:0] rsp_epoch;
  logic               rsp_compressed;

  modport master (
    output req_valid,
    output req_pc,
    output req_epoch,
    input  req_ready,
    input  rsp_valid,
    input  rsp_epoch,
    input  rsp_compressed
  );

  modport slave (
    input  req_valid,
    input  req_pc,
    input  req_epoch,
    output req_ready,
    output rsp_valid,
    output rsp_epoch,
    output rsp_compressed
  );

endinterface

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC generator with epoch-tagged single-outstanding requests
//
// Purpose: holds the architectural fetch PC, issues one fetch request at a time
// to the I-side and advances the PC by 2 or 4 when the matching response
// returns. Trap and branch/jump redirects reload the PC and bump the epoch so
// that responses belonging to the old instruction stream are dropped.
//
// Parameters:
//   XLEN      PC width in bits
//   RESET_PC  PC value loaded on reset
//   EPOCH_W   epoch tag width (2 or more)
//   C_EXT     1: 16-bit instructions allowed (step 2 or 4); 0: step is always 4
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   trap_en       trap redirect request (wins over bj_en)
//   trap_pc       trap target
//   bj_en         branch/jump redirect request
//   bj_pc         branch/jump target
//   stall         downstream stall, freezes PC advance
//   fif           fetch request/response bundle (master side)
//   pc            current fetch PC
//   misalign_err  one-cycle pulse after a redirect to a misaligned target

module fetch_pc_gen #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              EPOCH_W  = 2,
  parameter int              C_EXT    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trap_en,
  input  logic [XLEN-1:0]     trap_pc,
  input  logic                bj_en,
  input  logic [XLEN-1:0]     bj_pc,
  input  logic                stall,
  fetch_pc_gen_if.master      fif,
  output logic [XLEN-1:0]     pc,
  output logic                misalign_err
);

  localparam bit C_ON = (C_EXT != 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t             state_q;
  logic [XLEN-1:0]    pc_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic               req_valid_q;
  logic               misalign_q;
  // Step latched while a stalled response waits in HOLD: 1 means +2, 0 means +4.
  logic               step2_q;

  logic               redirect;
  logic [XLEN-1:0]    target;
  logic               target_misaligned;
  logic               rsp_hit;
  logic               step2_now;
  logic [EPOCH_W-1:0] epoch_inc;

  assign redirect          = trap_en | bj_en;
  assign target            = trap_en ? trap_pc : bj_pc;
  // Without compressed support every instruction is 4-byte aligned.
  assign target_misaligned = target[0] | (~C_ON & target[1]);
  assign rsp_hit           = fif.rsp_valid && (fif.rsp_epoch == epoch_q);
  assign step2_now         = C_ON & fif.rsp_compressed;
  assign epoch_inc         = epoch_q + EPOCH_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      epoch_q     <= '0;
      req_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      step2_q     <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (redirect) begin
        // A redirect overrides any handshake or response in the same cycle;
        // the epoch bump makes any in-flight response stale.
        pc_q    <= target;
        epoch_q <= epoch_inc;
        if (target_misaligned) begin
          state_q     <= FAULT;
          req_valid_q <= 1'b0;
          misalign_q  <= 1'b1;
        end else begin
          state_q     <= RUN;
          req_valid_q <= 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            state_q     <= RUN;
            req_valid_q <= 1'b1;
          end
          RUN: begin
            if (req_valid_q && fif.req_ready) begin
              state_q     <= WAIT;
              req_valid_q <= 1'b0;
            end
          end
          WAIT: begin
            if (rsp_hit) begin
              if (!stall) begin
                pc_q        <= pc_q + (step2_now ? XLEN'(2) : XLEN'(4));
                state_q     <= RUN;
                req_valid_q <= 1'b1;
              end else begin
                step2_q <= step2_now;
                state_q <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!stall) begin
              pc_q        <= pc_q + (step2_q ? XLEN'(2) : XLEN'(4));
              state_q     <= RUN;
              req_valid_q <= 1'b1;
            end
          end
          FAULT: begin
            req_valid_q <= 1'b0;
          end
          default: begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fif.req_valid = req_valid_q;
  assign fif.req_pc    = pc_q;
  assign fif.req_epoch = epoch_q;
  assign pc            = pc_q;
  assign misalign_err  = misalign_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - scoreboard bench for fetch_pc_gen (C_EXT=1 main DUT, C_EXT=0 side DUT)

module tb_fetch_pc_gen;

  localparam int XLEN    = 64;
  localparam int EPOCH_W = 2;

  typedef struct {
    logic [XLEN-1:0]    pc;
    logic [EPOCH_W-1:0] ep;
  } exp_t;

  logic clk;
  logic rst_n;

  logic            trap_en, bj_en, stall;
  logic [XLEN-1:0] trap_pc, bj_pc;
  logic [XLEN-1:0] pc0;
  logic            mis0;

  logic            trap_en1, bj_en1, stall1;
  logic [XLEN-1:0] trap_pc1, bj_pc1;
  logic [XLEN-1:0] pc1;
  logic            mis1;

  fetch_pc_gen_if #(.XLEN(XLEN), .EPOCH_W(EPOCH_W)) bus0 ();
  fetch_pc_gen_if #(.XLEN(XLEN), .EPOCH_W(EPOCH_W)) bus1 ();

  fetch_pc_gen #(.XLEN(XLEN), .RESET_PC('0), .EPOCH_W(EPOCH_W), .C_EXT(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .trap_en(trap_en), .trap_pc(trap_pc),
    .bj_en(bj_en), .bj_pc(bj_pc),
    .stall(stall), .fif(bus0.master),
    .pc(pc0), .misalign_err(mis0)
  );

  fetch_pc_gen #(.XLEN(XLEN), .RESET_PC('0), .EPOCH_W(EPOCH_W), .C_EXT(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .trap_en(trap_en1), .trap_pc(trap_pc1),
    .bj_en(bj_en1), .bj_pc(bj_pc1),
    .stall(stall1), .fif(bus1.master),
    .pc(pc1), .misalign_err(mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];
  exp_t e;
  logic [EPOCH_W-1:0] exp_epoch;
  bit ok;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus0.req_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic handshake0();
    bus0.req_ready = 1'b1;
    tick();
    bus0.req_ready = 1'b0;
  endtask

  task automatic respond0(input logic [EPOCH_W-1:0] ep, input logic comp);
    bus0.rsp_valid      = 1'b1;
    bus0.rsp_epoch      = ep;
    bus0.rsp_compressed = comp;
    tick();
    bus0.rsp_valid      = 1'b0;
    bus0.rsp_compressed = 1'b0;
  endtask

  task automatic redirect_bj0(input logic [XLEN-1:0] tgt);
    bj_en = 1'b1;
    bj_pc = tgt;
    tick();
    bj_en = 1'b0;
    exp_epoch = exp_epoch + 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (pc0 !== 64'h0 || bus0.req_valid !== 1'b0 || mis0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold pc=%h req_valid=%b mis=%b expected pc=0 req_valid=0 mis=0", pc0, bus0.req_valid, mis0);
    end
    rst_n = 1'b1;
    exp_epoch = '0;
    checks++;
    if (bus0.req_valid !== 1'b0 || pc0 !== 64'h0) begin
      failures++;
      $display("FAIL reset_cycle1 req_valid=%b pc=%h expected req_valid=0 pc=0", bus0.req_valid, pc0);
    end
    sb_q.push_back('{pc: 64'h0, ep: exp_epoch});
    tick();
    e = sb_q.pop_front();
    checks++;
    if (bus0.req_valid !== 1'b1 || bus0.req_pc !== e.pc || bus0.req_epoch !== e.ep) begin
      failures++;
      $display("FAIL reset_cycle2 req_valid=%b pc=%h ep=%0d expected 1 pc=%h ep=%0d", bus0.req_valid, bus0.req_pc, bus0.req_epoch, e.pc, e.ep);
    end
  endtask

  task automatic test_step();
    redirect_bj0(64'h100);
    sb_q.push_back('{pc: 64'h100, ep: exp_epoch});
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || bus0.req_pc !== e.pc || bus0.req_epoch !== e.ep) begin
      failures++;
      $display("FAIL step_start pc=%h ep=%0d expected pc=%h ep=%0d", bus0.req_pc, bus0.req_epoch, e.pc, e.ep);
    end
    tick();
    tick();
    checks++;
    if (bus0.req_valid !== 1'b1 || bus0.req_pc !== 64'h100) begin
      failures++;
      $display("FAIL req_stable req_valid=%b pc=%h expected 1 pc=100", bus0.req_valid, bus0.req_pc);
    end
    handshake0();
    checks++;
    if (bus0.req_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_no_req req_valid=%b expected 0", bus0.req_valid);
    end
    sb_q.push_back('{pc: 64'h102, ep: exp_epoch});
    respond0(exp_epoch, 1'b1);
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || bus0.req_pc !== e.pc || bus0.req_epoch !== e.ep) begin
      failures++;
      $display("FAIL step_c16 pc=%h ep=%0d expected pc=%h ep=%0d", bus0.req_pc, bus0.req_epoch, e.pc, e.ep);
    end
    handshake0();
    sb_q.push_back('{pc: 64'h106, ep: exp_epoch});
    respond0(exp_epoch, 1'b0);
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || bus0.req_pc !== e.pc || bus0.req_epoch !== e.ep) begin
      failures++;
      $display("FAIL step_i32 pc=%h ep=%0d expected pc=%h ep=%0d", bus0.req_pc, bus0.req_epoch, e.pc, e.ep);
    end
  endtask

  task automatic test_redirect_wait();
    logic [EPOCH_W-1:0] old_ep;
    handshake0();
    old_ep = exp_epoch;
    redirect_bj0(64'h2000);
    sb_q.push_back('{pc: 64'h2000, ep: exp_epoch});
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || bus0.req_pc !== e.pc || bus0.req_epoch !== e.ep) begin
      failures++;
      $display("FAIL redir_wait pc=%h ep=%0d expected pc=%h ep=%0d", bus0.req_pc, bus0.req_epoch, e.pc, e.ep);
    end
    handshake0();
    respond0(old_ep, 1'b0);
    tick();
    checks++;
    if (pc0 !== 64'h2000 || bus0.req_valid !== 1'b0) begin
      failures++;
      $display("FAIL stale_drop pc=%h req_valid=%b expected pc=2000 req_valid=0", pc0, bus0.req_valid);
    end
    sb_q.push_back('{pc: 64'h2004, ep: exp_epoch});
    respond0(exp_epoch, 1'b0);
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || bus0.req_pc !== e.pc || bus0.req_epoch !== e.ep) begin
      failures++;
      $display("FAIL after_stale pc=%h ep=%0d expected pc=%h ep=%0d", bus0.req_pc, bus0.req_epoch, e.pc, e.ep);
    end
  endtask

  task automatic test_trap_priority();
    trap_en = 1'b1;
    trap_pc = 64'h80;
    bj_en   = 1'b1;
    bj_pc   = 64'h400;
    bus0.req_ready = 1'b1;
    tick();
    trap_en = 1'b0;
    bj_en   = 1'b0;
    bus0.req_ready = 1'b0;
    exp_epoch = exp_epoch + 1'b1;
    sb_q.push_back('{pc: 64'h80, ep: exp_epoch});
    e = sb_q.pop_front();
    checks++;
    if (bus0.req_valid !== 1'b1 || bus0.req_pc !== e.pc || bus0.req_epoch !== e.ep) begin
      failures++;
      $display("FAIL trap_wins req_valid=%b pc=%h ep=%0d expected 1 pc=%h ep=%0d", bus0.req_valid, bus0.req_pc, bus0.req_epoch, e.pc, e.ep);
    end
  endtask

  task automatic test_misalign();
    redirect_bj0(64'h1001);
    checks++;
    if (mis0 !== 1'b1 || bus0.req_valid !== 1'b0 || pc0 !== 64'h1001 || bus0.req_epoch !== exp_epoch) begin
      failures++;
      $display("FAIL misalign_pulse mis=%b req_valid=%b pc=%h ep=%0d expected 1 0 pc=1001 ep=%0d", mis0, bus0.req_valid, pc0, bus0.req_epoch, exp_epoch);
    end
    tick();
    checks++;
    if (mis0 !== 1'b0 || bus0.req_valid !== 1'b0) begin
      failures++;
      $display("FAIL misalign_one_cycle mis=%b req_valid=%b expected 0 0", mis0, bus0.req_valid);
    end
    respond0(exp_epoch, 1'b0);
    tick();
    checks++;
    if (pc0 !== 64'h1001 || bus0.req_valid !== 1'b0) begin
      failures++;
      $display("FAIL fault_ignores_rsp pc=%h req_valid=%b expected pc=1001 req_valid=0", pc0, bus0.req_valid);
    end
    trap_en = 1'b1;
    trap_pc = 64'h80;
    tick();
    trap_en = 1'b0;
    exp_epoch = exp_epoch + 1'b1;
    sb_q.push_back('{pc: 64'h80, ep: exp_epoch});
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || bus0.req_pc !== e.pc || bus0.req_epoch !== e.ep || mis0 !== 1'b0) begin
      failures++;
      $display("FAIL fault_exit pc=%h ep=%0d mis=%b expected pc=%h ep=%0d mis=0", bus0.req_pc, bus0.req_epoch, mis0, e.pc, e.ep);
    end
  endtask

  task automatic test_no_c_ext();
    bj_en1 = 1'b1;
    bj_pc1 = 64'h1002;
    tick();
    bj_en1 = 1'b0;
    checks++;
    if (mis1 !== 1'b1 || bus1.req_valid !== 1'b0) begin
      failures++;
      $display("FAIL noc_misalign mis=%b req_valid=%b expected 1 0", mis1, bus1.req_valid);
    end
    bj_en1 = 1'b1;
    bj_pc1 = 64'h1004;
    tick();
    bj_en1 = 1'b0;
    checks++;
    if (mis1 !== 1'b0 || bus1.req_valid !== 1'b1 || pc1 !== 64'h1004 || bus1.req_epoch !== 2'd2) begin
      failures++;
      $display("FAIL noc_aligned mis=%b req_valid=%b pc=%h ep=%0d expected 0 1 pc=1004 ep=2", mis1, bus1.req_valid, pc1, bus1.req_epoch);
    end
    bus1.req_ready = 1'b1;
    tick();
    bus1.req_ready      = 1'b0;
    bus1.rsp_valid      = 1'b1;
    bus1.rsp_epoch      = 2'd2;
    bus1.rsp_compressed = 1'b1;
    tick();
    bus1.rsp_valid      = 1'b0;
    bus1.rsp_compressed = 1'b0;
    checks++;
    if (pc1 !== 64'h1008 || bus1.req_valid !== 1'b1) begin
      failures++;
      $display("FAIL noc_step4 pc=%h req_valid=%b expected pc=1008 req_valid=1", pc1, bus1.req_valid);
    end
  endtask

  task automatic test_stall();
    handshake0();
    stall = 1'b1;
    respond0(exp_epoch, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pc0 !== 64'h80 || bus0.req_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_freeze[%0d] pc=%h req_valid=%b expected pc=80 req_valid=0", i, pc0, bus0.req_valid);
      end
      tick();
    end
    stall = 1'b0;
    sb_q.push_back('{pc: 64'h84, ep: exp_epoch});
    tick();
    e = sb_q.pop_front();
    checks++;
    if (bus0.req_valid !== 1'b1 || bus0.req_pc !== e.pc || bus0.req_epoch !== e.ep) begin
      failures++;
      $display("FAIL stall_release req_valid=%b pc=%h expected 1 pc=%h", bus0.req_valid, bus0.req_pc, e.pc);
    end
    handshake0();
    stall = 1'b1;
    respond0(exp_epoch, 1'b1);
    tick();
    checks++;
    if (pc0 !== 64'h84) begin
      failures++;
      $display("FAIL stall_c16_freeze pc=%h expected pc=84", pc0);
    end
    stall = 1'b0;
    sb_q.push_back('{pc: 64'h86, ep: exp_epoch});
    tick();
    e = sb_q.pop_front();
    checks++;
    if (bus0.req_valid !== 1'b1 || bus0.req_pc !== e.pc) begin
      failures++;
      $display("FAIL stall_latched_step req_valid=%b pc=%h expected 1 pc=%h", bus0.req_valid, bus0.req_pc, e.pc);
    end
  endtask

  task automatic test_wrap();
    redirect_bj0(64'hFFFF_FFFF_FFFF_FFFC);
    sb_q.push_back('{pc: 64'hFFFF_FFFF_FFFF_FFFC, ep: exp_epoch});
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || bus0.req_pc !== e.pc || bus0.req_epoch !== e.ep) begin
      failures++;
      $display("FAIL wrap_start pc=%h ep=%0d expected pc=%h ep=%0d", bus0.req_pc, bus0.req_epoch, e.pc, e.ep);
    end
    handshake0();
    sb_q.push_back('{pc: 64'h0, ep: exp_epoch});
    respond0(exp_epoch, 1'b0);
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || bus0.req_pc !== e.pc || bus0.req_epoch !== e.ep) begin
      failures++;
      $display("FAIL wrap_zero pc=%h ep=%0d expected pc=%h ep=%0d", bus0.req_pc, bus0.req_epoch, e.pc, e.ep);
    end
  endtask

  task automatic test_reset_mid_request();
    redirect_bj0(64'h300);
    handshake0();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc0 !== 64'h0 || bus0.req_valid !== 1'b0 || bus0.req_epoch !== 2'd0) begin
      failures++;
      $display("FAIL async_reset pc=%h req_valid=%b ep=%0d expected pc=0 req_valid=0 ep=0", pc0, bus0.req_valid, bus0.req_epoch);
    end
    tick();
    rst_n = 1'b1;
    exp_epoch = '0;
    sb_q.push_back('{pc: 64'h0, ep: exp_epoch});
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || bus0.req_pc !== e.pc || bus0.req_epoch !== e.ep) begin
      failures++;
      $display("FAIL reset_restart pc=%h ep=%0d expected pc=%h ep=%0d", bus0.req_pc, bus0.req_epoch, e.pc, e.ep);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    trap_en = 1'b0;  trap_pc = '0;
    bj_en   = 1'b0;  bj_pc   = '0;
    stall   = 1'b0;
    trap_en1 = 1'b0; trap_pc1 = '0;
    bj_en1   = 1'b0; bj_pc1   = '0;
    stall1   = 1'b0;
    bus0.req_ready = 1'b0; bus0.rsp_valid = 1'b0; bus0.rsp_epoch = '0; bus0.rsp_compressed = 1'b0;
    bus1.req_ready = 1'b0; bus1.rsp_valid = 1'b0; bus1.rsp_epoch = '0; bus1.rsp_compressed = 1'b0;
    exp_epoch = '0;

    test_reset();
    test_step();
    test_redirect_wait();
    test_trap_priority();
    test_misalign();
    test_no_c_ext();
    test_stall();
    test_wrap();
    test_reset_mid_request();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
